// File: rtl/systolic_feed_scheduler_if.sv
// Job-command and feeder-control bundle for the systolic feed scheduler.
// The scheduler connects via the slave modport; the job source and feeder side use master.
interface systolic_feed_scheduler_if #(
   parameter int TW = 4
);
   logic          iCmdValid;
   logic          oCmdReady;
   logic [TW-1:0] iNumTiles;
   logic          iFinishedRearranging;
   logic          iAbort;
   logic          oRearrRst_n;
   logic          oLoad;
   logic          oFeedEn;
   logic          oClearAcc;
   logic [TW-1:0] oTileIdx;
   logic          oBusy;
   logic          oDone;
   logic          oError;

   modport slave (
      input  iCmdValid, iNumTiles, iFinishedRearranging, iAbort,
      output oCmdReady, oRearrRst_n, oLoad, oFeedEn, oClearAcc,
             oTileIdx, oBusy, oDone, oError
   );

   modport master (
      output iCmdValid, iNumTiles, iFinishedRearranging, iAbort,
      input  oCmdReady, oRearrRst_n, oLoad, oFeedEn, oClearAcc,
             oTileIdx, oBusy, oDone, oError
   );
endinterface

// File: rtl/systolic_feed_scheduler.sv
// Systolic array feed scheduler: sequences load / feed / drain per tile of a job.
// Optional macro SCHED_PERF_CNT_EN adds the 16-bit oCycleCnt job-length counter.
//
// state | meaning
// IDLE  | waiting for a job, oCmdReady high
// LOAD  | one cycle: latch operands, restart feeder, clear accumulators on tile 0
// FEED  | operands advancing until feeder finishes or 2N-cycle timeout
// DRAIN | N cycles with feed stopped so the array empties
// DONE  | one-cycle completion pulse
module systolic_feed_scheduler #(
   parameter int BW = 8,
   parameter int N  = 5,
   parameter int TW = 4
) (
   input  logic clk,
   input  logic rst,
`ifdef SCHED_PERF_CNT_EN
   output logic [15:0] oCycleCnt,
`endif
   systolic_feed_scheduler_if.slave bus
);

   localparam int CntW = (N < 1) ? 1 : $clog2(2 * N);

   // Elaboration-time sanity on the parameter set; BW only documents the feeder width.
   if (BW < 1 || N < 1 || TW < 1) begin : gParamCheck
      $error("systolic_feed_scheduler: BW, N and TW must all be at least 1");
   end

   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

   state_t        state;
   state_t        stateNext;
   logic [CntW-1:0] phaseCnt;
   logic [TW-1:0] numTiles;
   logic [TW-1:0] tileIdx;
   logic          errFlag;
   logic          rstHold;
   logic [TW:0]   tileNext;
   logic          moreTiles;
   logic          feedTimeout;
   logic          drainEnd;

   // One extra bit so a count of 2^TW-1 tiles still terminates correctly.
   assign tileNext    = {1'b0, tileIdx} + {{TW{1'b0}}, 1'b1};
   assign moreTiles   = tileNext < {1'b0, numTiles};
   assign feedTimeout = phaseCnt == CntW'(2 * N - 1);
   assign drainEnd    = phaseCnt == CntW'(N - 1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next-state decode; abort outranks a simultaneous finish.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (bus.iCmdValid) stateNext = (bus.iNumTiles == '0) ? DONE : LOAD;
         end
         LOAD: begin
            stateNext = bus.iAbort ? DONE : FEED;
         end
         FEED: begin
            if (bus.iAbort)                    stateNext = DONE;
            else if (bus.iFinishedRearranging) stateNext = DRAIN;
            else if (feedTimeout)              stateNext = DONE;
         end
         DRAIN: begin
            if (bus.iAbort)  stateNext = DONE;
            else if (drainEnd) stateNext = moreTiles ? LOAD : DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Job context: tile count, tile index, phase counter, sticky error, reset echo.
   always_ff @(posedge clk) begin
      if (rst) begin
         numTiles <= '0;
         tileIdx  <= '0;
         phaseCnt <= '0;
         errFlag  <= 1'b0;
         rstHold  <= 1'b1;
      end else begin
         rstHold <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iCmdValid) begin
                  numTiles <= bus.iNumTiles;
                  tileIdx  <= '0;
                  phaseCnt <= '0;
                  errFlag  <= 1'b0;
               end
            end
            LOAD: begin
               phaseCnt <= '0;
               if (bus.iAbort) errFlag <= 1'b1;
            end
            FEED: begin
               if (bus.iAbort) begin
                  errFlag <= 1'b1;
               end else if (bus.iFinishedRearranging) begin
                  phaseCnt <= '0;
               end else if (feedTimeout) begin
                  errFlag <= 1'b1;
               end else begin
                  phaseCnt <= phaseCnt + CntW'(1);
               end
            end
            DRAIN: begin
               if (bus.iAbort) begin
                  errFlag <= 1'b1;
               end else if (drainEnd) begin
                  phaseCnt <= '0;
                  if (moreTiles) tileIdx <= tileNext[TW-1:0];
               end else begin
                  phaseCnt <= phaseCnt + CntW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Moore output decode from registered state only.
   always_comb begin
      bus.oCmdReady   = state == IDLE;
      bus.oLoad       = state == LOAD;
      bus.oRearrRst_n = (state != LOAD) && !rstHold;
      bus.oFeedEn     = state == FEED;
      bus.oClearAcc   = (state == LOAD) && (tileIdx == '0);
      bus.oTileIdx    = tileIdx;
      bus.oBusy       = (state == LOAD) || (state == FEED) || (state == DRAIN);
      bus.oDone       = state == DONE;
      bus.oError      = errFlag;
   end

`ifdef SCHED_PERF_CNT_EN
   logic [15:0] cycleCnt;

   // Job length in cycles, LOAD through DONE, saturating and held while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycleCnt <= '0;
      end else if (state == IDLE) begin
         if (bus.iCmdValid) cycleCnt <= '0;
      end else if (cycleCnt != 16'hFFFF) begin
         cycleCnt <= cycleCnt + 16'd1;
      end
   end

   assign oCycleCnt = cycleCnt;
`endif

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Directed scoreboard bench for systolic_feed_scheduler (N=5, TW=4).
module tb_systolic_feed_scheduler;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic [3:0] nt;
      logic       fin;
      logic       abort;
   } stim_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   scen   = 0;

   stim_t       stimQ[$];
   logic [11:0] expQ[$];

   systolic_feed_scheduler_if #(.TW(4)) bus ();

`ifdef SCHED_PERF_CNT_EN
   logic [15:0] cycleCnt;
`endif

   systolic_feed_scheduler #(.BW(8), .N(5), .TW(4)) dut (
      .clk(clk),
      .rst(rst),
`ifdef SCHED_PERF_CNT_EN
      .oCycleCnt(cycleCnt),
`endif
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vector {ready,load,rrst_n,feedEn,clearAcc,busy,done,error,tileIdx}.
   function automatic logic [11:0] expVec(input byte ph, input logic [3:0] t, input logic e);
      logic ready, load, rrst, feed, clr, busy, done;
      ready = 1'b0; load = 1'b0; rrst = 1'b1; feed = 1'b0;
      clr = 1'b0; busy = 1'b0; done = 1'b0;
      case (ph)
         "I": ready = 1'b1;
         "L": begin load = 1'b1; rrst = 1'b0; clr = (t == 4'd0); busy = 1'b1; end
         "F": begin feed = 1'b1; busy = 1'b1; end
         "R": busy = 1'b1;
         "D": done = 1'b1;
         "X": begin ready = 1'b1; rrst = 1'b0; end
         default: ready = 1'b0;
      endcase
      return {ready, load, rrst, feed, clr, busy, done, e, t};
   endfunction

   task automatic add(input logic r, input logic v, input logic [3:0] nt, input logic f,
                      input logic a, input byte ph, input logic [3:0] t, input logic e);
      stim_t s;
      s.rst = r; s.valid = v; s.nt = nt; s.fin = f; s.abort = a;
      stimQ.push_back(s);
      expQ.push_back(expVec(ph, t, e));
   endtask

   task automatic addN(input int n, input byte ph, input logic [3:0] t, input logic e);
      for (int i = 0; i < n; i++) add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ph, t, e);
   endtask

   task automatic runQueued();
      stim_t       s;
      logic [11:0] e;
      logic [11:0] o;
      int          cyc;
      cyc = 0;
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         e = expQ.pop_front();
         rst                      = s.rst;
         bus.iCmdValid            = s.valid;
         bus.iNumTiles            = s.nt;
         bus.iFinishedRearranging = s.fin;
         bus.iAbort               = s.abort;
         @(negedge clk);
         o = {bus.oCmdReady, bus.oLoad, bus.oRearrRst_n, bus.oFeedEn, bus.oClearAcc,
              bus.oBusy, bus.oDone, bus.oError, bus.oTileIdx};
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL outputs scen%0d cyc%0d observed=%h expected=%h", scen, cyc, o, e);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      rst                      = 1'b0;
      bus.iCmdValid            = 1'b0;
      bus.iNumTiles            = 4'd0;
      bus.iFinishedRearranging = 1'b0;
      bus.iAbort               = 1'b0;
   endtask

`ifdef SCHED_PERF_CNT_EN
   task automatic checkCnt(input logic [15:0] want);
      checks++;
      assert (cycleCnt === want) else begin
         errors++;
         $error("FAIL cycleCnt scen%0d observed=%0d expected=%0d", scen, cycleCnt, want);
      end
   endtask
`endif

   initial begin
      rst                      = 1'b1;
      bus.iCmdValid            = 1'b0;
      bus.iNumTiles            = 4'd0;
      bus.iFinishedRearranging = 1'b0;
      bus.iAbort               = 1'b0;
      @(posedge clk);
      #1;

      // Reset values, then feeder restart released one cycle after rst drops.
      scen = 0;
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "X", 4'd0, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "X", 4'd0, 1'b0);
      addN(1, "I", 4'd0, 1'b0);
      runQueued();
`ifdef SCHED_PERF_CNT_EN
      checkCnt(16'd0);
`endif

      // One tile, feeder done at cycle 10.
      scen = 1;
      add(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, "I", 4'd0, 1'b0);
      addN(1, "L", 4'd0, 1'b0);
      addN(8, "F", 4'd0, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "F", 4'd0, 1'b0);
      addN(5, "R", 4'd0, 1'b0);
      addN(1, "D", 4'd0, 1'b0);
      addN(1, "I", 4'd0, 1'b0);
      runQueued();
`ifdef SCHED_PERF_CNT_EN
      checkCnt(16'd16);
`endif

      // Three tiles, nine FEED cycles each.
      scen = 2;
      add(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, "I", 4'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         addN(1, "L", 4'(k), 1'b0);
         addN(8, "F", 4'(k), 1'b0);
         add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "F", 4'(k), 1'b0);
         addN(5, "R", 4'(k), 1'b0);
      end
      addN(1, "D", 4'd2, 1'b0);
      addN(1, "I", 4'd2, 1'b0);
      runQueued();

      // Feeder never finishes: timeout after 2N FEED cycles.
      scen = 3;
      add(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, "I", 4'd2, 1'b0);
      addN(1, "L", 4'd0, 1'b0);
      addN(10, "F", 4'd0, 1'b0);
      addN(1, "D", 4'd0, 1'b1);
      addN(1, "I", 4'd0, 1'b1);
      runQueued();

      // Abort beats finish in FEED cycle 5.
      scen = 4;
      add(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, "I", 4'd0, 1'b1);
      addN(1, "L", 4'd0, 1'b0);
      addN(3, "F", 4'd0, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "F", 4'd0, 1'b0);
      addN(1, "D", 4'd0, 1'b1);
      addN(1, "I", 4'd0, 1'b1);
      runQueued();

      // Zero-tile job completes straight away and clears the old error.
      scen = 5;
      add(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "I", 4'd0, 1'b1);
      addN(1, "D", 4'd0, 1'b0);
      addN(1, "I", 4'd0, 1'b0);
      runQueued();
`ifdef SCHED_PERF_CNT_EN
      checkCnt(16'd1);
`endif

      // Reset during DRAIN of tile 1.
      scen = 6;
      add(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, "I", 4'd0, 1'b0);
      addN(1, "L", 4'd0, 1'b0);
      addN(8, "F", 4'd0, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "F", 4'd0, 1'b0);
      addN(5, "R", 4'd0, 1'b0);
      addN(1, "L", 4'd1, 1'b0);
      addN(8, "F", 4'd1, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "F", 4'd1, 1'b0);
      addN(1, "R", 4'd1, 1'b0);
      add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "R", 4'd1, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "X", 4'd0, 1'b0);
      addN(2, "I", 4'd0, 1'b0);
      runQueued();
`ifdef SCHED_PERF_CNT_EN
      checkCnt(16'd0);
`endif

      // Abort in LOAD; abort and finish ignored in DONE and IDLE.
      scen = 7;
      add(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, "I", 4'd0, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "L", 4'd0, 1'b0);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "D", 4'd0, 1'b1);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "I", 4'd0, 1'b1);
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "I", 4'd0, 1'b1);
      addN(1, "I", 4'd0, 1'b1);
      runQueued();

      // Largest tile count runs all 15 tiles without index wrap.
      scen = 8;
      add(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, "I", 4'd0, 1'b1);
      for (int k = 0; k < 15; k++) begin
         addN(1, "L", 4'(k), 1'b0);
         add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "F", 4'(k), 1'b0);
         addN(5, "R", 4'(k), 1'b0);
      end
      addN(1, "D", 4'd14, 1'b0);
      addN(1, "I", 4'd14, 1'b0);
      runQueued();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feed_scheduler.md
SYSTOLIC_FEED_SCHEDULER -- requirements
Module: systolic_feed_scheduler

Interface
REQ-001 SHALL have parameter BW, default 8: operand element width, passed through to the feeder for documentation only.
REQ-002 SHALL have parameter N, default 5: systolic array dimension, which sets the feed and drain cycle counts.
REQ-003 SHALL have parameter TW, default 4: width of the tile count and tile index.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port iCmdValid, input, 1 bit: job request.
REQ-007 SHALL have port oCmdReady, output, 1 bit: the scheduler can accept a job.
REQ-008 SHALL have port iNumTiles, input, TW bits: number of accumulated tiles in the job; sampled only on accept.
REQ-009 SHALL have port iFinishedRearranging, input, 1 bit: the feeder's finished flag.
REQ-010 SHALL have port iAbort, input, 1 bit: cancels the current job.
REQ-011 SHALL have port oRearrRst_n, output, 1 bit: active-low restart for the feeder.
REQ-012 SHALL have port oLoad, output, 1 bit: latch the operand matrices into the feeder.
REQ-013 SHALL have port oFeedEn, output, 1 bit: the feeder and PE array are advancing operands.
REQ-014 SHALL have port oClearAcc, output, 1 bit: clear the PE accumulators.
REQ-015 SHALL have port oTileIdx, output, TW bits: index of the current tile.
REQ-016 SHALL have port oBusy, output, 1 bit: a job is in progress.
REQ-017 SHALL have port oDone, output, 1 bit: one-cycle job-completion pulse.
REQ-018 SHALL have port oError, output, 1 bit: the job ended by timeout or abort; sticky until the next accept.

Function
REQ-019 SHALL implement a state machine with states IDLE, LOAD, FEED, DRAIN and DONE.
REQ-020 SHALL drive oCmdReady=1 only in IDLE; accept occurs when iCmdValid and oCmdReady are both 1 at a clock edge.
REQ-021 SHALL on accept latch iNumTiles, clear oTileIdx, clear oError and the FEED/DRAIN counter, and move to LOAD, or to DONE if iNumTiles=0.
REQ-022 SHALL in LOAD, for exactly 1 cycle, drive oLoad=1, oRearrRst_n=0, and oClearAcc=1 only when oTileIdx=0; the next state is FEED.
REQ-023 SHALL in FEED drive oFeedEn=1 and increment the cycle counter each cycle, starting from 0.
REQ-024 SHALL in FEED go to DRAIN when iFinishedRearranging=1 is sampled.
REQ-025 SHALL in FEED, if the counter reaches 2N without iFinishedRearranging, set oError and go to DONE.
REQ-026 SHALL in DRAIN hold oFeedEn=0 for exactly N cycles.
REQ-027 SHALL at the end of DRAIN go to LOAD with oTileIdx+1 if oTileIdx+1 < latched count, else to DONE.
REQ-028 SHALL in DONE drive oDone=1 for exactly 1 cycle, then go to IDLE.
REQ-029 SHALL drive oBusy=1 in LOAD, FEED and DRAIN only.
REQ-030 SHALL on iAbort=1 in LOAD, FEED or DRAIN set oError and go to DONE on the next cycle.
REQ-031 SHALL ignore iAbort in IDLE and DONE.
REQ-032 SHALL give iAbort priority over a simultaneous iFinishedRearranging.
REQ-033 SHALL ignore iFinishedRearranging outside FEED.
REQ-034 SHALL hold oRearrRst_n=1 in every state other than LOAD.
REQ-035 SHALL compute the tile index compare at TW+1 bits so that iNumTiles=2^TW-1 completes without wrap.
REQ-036 SHALL register all outputs, i.e. drive them as pure functions of registered state.

Reset
REQ-037 SHALL on rst=1 at a clock edge enter IDLE from any state, abandoning any job with no oDone pulse.
REQ-038 SHALL hold the following reset values: oCmdReady=1, oLoad=0, oFeedEn=0, oClearAcc=0, oBusy=0, oDone=0, oError=0, oTileIdx=0, oRearrRst_n=0.
REQ-039 SHALL release oRearrRst_n to 1 in the first cycle after rst deasserts.

Configuration
REQ-040 SHALL, with macro SCHED_PERF_CNT_EN defined, add output port oCycleCnt, 16 bits: cleared on accept, incremented each cycle from LOAD through DONE inclusive, saturating at 16'hFFFF, held in IDLE, reset to 0.
REQ-041 SHALL, without SCHED_PERF_CNT_EN, omit the oCycleCnt port and its logic; all other behaviour is identical.

Verification
REQ-042 SHALL cover: N=5, 1 tile, accept at cycle 0, iFinishedRearranging at cycle 10 -> LOAD in cycle 1, oFeedEn high in cycles 2-10, DRAIN in 11-15, oDone in 16, oCycleCnt=16, oError=0.
REQ-043 SHALL cover: N=5, 3 tiles, feeder finishes after 9 FEED cycles each -> oLoad pulses in cycles 1, 16, 31; oClearAcc only in cycle 1; oTileIdx steps 0, 1, 2; oDone in cycle 46.
REQ-044 SHALL cover: feeder never finishes -> oFeedEn high in cycles 2-11, oDone with oError=1 in cycle 12, back to IDLE in cycle 13.
REQ-045 SHALL cover: iAbort and iFinishedRearranging both 1 in FEED cycle 5 -> no DRAIN, oDone in cycle 6 with oError=1; next accept clears oError.
REQ-046 SHALL cover: iNumTiles=0 accepted -> oDone in cycle 1, no oLoad, oError=0.
REQ-047 SHALL cover: rst=1 during DRAIN of tile 1 -> next cycle all outputs at reset values, no oDone, oCmdReady=1 after release.
